// File: rtl/ap_ctrl_stat_probe.sv
// Handshake statistics probe for one ap_ctrl_hs/ap_ctrl_chain sub-block.
// Emits one {ready_seen, stall, interval, latency} record per completed transaction.
module ap_ctrl_stat_probe #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               mon_start,
  input  logic               mon_ready,
  input  logic               mon_done,
  input  logic               mon_continue,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [3*CNT_W:0]   rec_data,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               overflow
);

  localparam int unsigned REC_W = 3 * CNT_W + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  logic [CNT_W-1:0] lat_cnt, stall_cnt, int_cnt, since_cnt;
  logic             have_start, rdy_seen;

  logic             start_acc, complete, rec_rdy;
  logic [CNT_W-1:0] rec_lat, rec_stall, rec_int, new_int;
  logic [REC_W-1:0] rec_in;

  // Record fields for a completion happening in this cycle.
  always_comb begin
    start_acc = 1'b0;
    complete  = 1'b0;
    rec_lat   = lat_cnt;
    rec_stall = stall_cnt;
    rec_int   = int_cnt;
    rec_rdy   = rdy_seen | mon_ready;
    new_int   = have_start ? sat_inc(since_cnt) : '0;
    case (state)
      IDLE: begin
        if (mon_start) begin
          start_acc = 1'b1;
          if (mon_done && mon_continue) begin
            complete  = 1'b1;
            rec_lat   = '0;
            rec_stall = '0;
            rec_int   = new_int;
            rec_rdy   = mon_ready;
          end
        end
      end
      BUSY: begin
        if (mon_done && mon_continue) begin
          complete  = 1'b1;
          rec_lat   = sat_inc(lat_cnt);
          rec_stall = '0;
          start_acc = mon_start;
        end
      end
      HOLD: begin
        if (mon_continue) begin
          complete  = 1'b1;
          start_acc = mon_start;
        end
      end
      default: ;
    endcase
    rec_in = {rec_rdy, rec_stall, rec_int, rec_lat};
  end

  // Handshake FSM and per-transaction counters.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      stall_cnt  <= '0;
      int_cnt    <= '0;
      since_cnt  <= '0;
      have_start <= 1'b0;
      rdy_seen   <= 1'b0;
    end else begin
      if (start_acc) begin
        since_cnt  <= '0;
        have_start <= 1'b1;
        int_cnt    <= new_int;
        rdy_seen   <= mon_ready;
        lat_cnt    <= '0;
        stall_cnt  <= '0;
      end else begin
        since_cnt  <= sat_inc(since_cnt);
      end
      case (state)
        IDLE: begin
          if (mon_start) begin
            if (mon_done && !mon_continue) begin
              state     <= HOLD;
              stall_cnt <= CNT_W'(1);
            end else if (!mon_done) begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mon_done && mon_continue) begin
            state <= mon_start ? BUSY : IDLE;
          end else begin
            lat_cnt  <= sat_inc(lat_cnt);
            rdy_seen <= rdy_seen | mon_ready;
            if (mon_done) begin
              state     <= HOLD;
              stall_cnt <= CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (mon_continue) begin
            state <= mon_start ? BUSY : IDLE;
          end else begin
            rdy_seen <= rdy_seen | mon_ready;
            if (mon_done) stall_cnt <= sat_inc(stall_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [OCC_W-1:0] occ, occ_next;
  logic             pop, full, push, drop;

  always_comb begin
    pop      = rec_valid && rec_ready;
    full     = (occ == OCC_W'(DEPTH));
    push     = complete && (!full || pop);
    drop     = complete && !push;
    rd_next  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    occ_next = occ + OCC_W'(push) - OCC_W'(pop);
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  // Head register bypasses the array when the new record lands at the head.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      rec_valid  <= 1'b0;
      rec_data   <= '0;
      txn_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      occ       <= occ_next;
      rec_valid <= (occ_next != '0);
      if (occ_next != '0) begin
        rec_data <= (push && (wr_ptr == rd_next)) ? rec_in : mem[rd_next];
      end
      if (complete) txn_count <= sat_inc(txn_count);
      if (drop) begin
        drop_count <= sat_inc(drop_count);
        overflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_stat_probe.sv
// Directed bench for ap_ctrl_stat_probe: one task per scenario, hand-computed records.
module tb_ap_ctrl_stat_probe;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned REC_W = 3 * CNT_W + 1;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             mon_start = 1'b0, mon_ready = 1'b0, mon_done = 1'b0, mon_continue = 1'b0;
  logic             rec_valid, rec_ready = 1'b0;
  logic [REC_W-1:0] rec_data;
  logic [CNT_W-1:0] txn_count, drop_count;
  logic             overflow;

  int vectors = 0;
  int miscompares = 0;
  logic [REC_W-1:0] got [$];

  ap_ctrl_stat_probe #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .mon_start(mon_start), .mon_ready(mon_ready), .mon_done(mon_done), .mon_continue(mon_continue),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .txn_count(txn_count), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  // Records that will be popped at the next rising edge.
  always @(negedge ap_clk) begin
    if (!ap_rst && rec_valid && rec_ready) got.push_back(rec_data);
  end

  function automatic logic [REC_W-1:0] mk(input logic rdy, input int stall, input int intv, input int lat);
    return {rdy, CNT_W'(stall), CNT_W'(intv), CNT_W'(lat)};
  endfunction

  // One monitored cycle: inputs sampled at the next rising edge.
  task automatic cyc(input logic s, input logic r, input logic d, input logic c);
    mon_start = s; mon_ready = r; mon_done = d; mon_continue = c;
    @(posedge ap_clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset;
    ap_rst = 1'b1; rec_ready = 1'b0;
    mon_start = 1'b0; mon_ready = 1'b0; mon_done = 1'b0; mon_continue = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    got.delete();
  endtask

  task automatic test_reset;
    do_reset();
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rec_valid got %0b want 0", rec_valid); end
    vectors++; if (rec_data !== '0) begin miscompares++; $display("FAIL reset_rec_data got %h want 0", rec_data); end
    vectors++; if (txn_count !== '0) begin miscompares++; $display("FAIL reset_txn_count got %0d want 0", txn_count); end
    vectors++; if (drop_count !== '0) begin miscompares++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_single;
    logic [REC_W-1:0] exp;
    do_reset();
    exp = mk(1'b1, 0, 0, 7);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle(6);
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_valid got %0b want 0", rec_valid); end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %0b want 1", rec_valid); end
    vectors++; if (txn_count !== CNT_W'(1)) begin miscompares++; $display("FAIL single_txn got %0d want 1", txn_count); end
    vectors++; if (rec_data !== exp) begin miscompares++; $display("FAIL single_rec got %h want %h", rec_data, exp); end
    idle(2);
    vectors++; if (rec_data !== exp) begin miscompares++; $display("FAIL single_hold got %h want %h", rec_data, exp); end
    rec_ready = 1'b1;
    idle(1);
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop got %0b want 0", rec_valid); end
  endtask

  task automatic test_back_to_back;
    logic [REC_W-1:0] exp [3];
    do_reset();
    rec_ready = 1'b1;
    exp[0] = mk(1'b0, 0, 0, 3); exp[1] = mk(1'b0, 0, 5, 3); exp[2] = mk(1'b0, 0, 5, 3);
    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      idle(1);
    end
    idle(3);
    vectors++; if (got.size() != 3) begin miscompares++; $display("FAIL b2b_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_rec%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
    vectors++; if (txn_count !== CNT_W'(3)) begin miscompares++; $display("FAIL b2b_txn got %0d want 3", txn_count); end
  endtask

  task automatic test_zero_latency;
    logic [REC_W-1:0] exp [3];
    do_reset();
    rec_ready = 1'b1;
    exp[0] = mk(1'b1, 0, 0, 0); exp[1] = mk(1'b1, 0, 1, 0); exp[2] = mk(1'b1, 0, 1, 0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    vectors++; if (got.size() != 3) begin miscompares++; $display("FAIL zero_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL zero_rec%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
    vectors++; if (txn_count !== CNT_W'(3)) begin miscompares++; $display("FAIL zero_txn got %0d want 3", txn_count); end
  endtask

  task automatic test_stall;
    logic [REC_W-1:0] exp [2];
    do_reset();
    rec_ready = 1'b1;
    exp[0] = mk(1'b1, 4, 0, 7); exp[1] = mk(1'b0, 0, 11, 2);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle(6);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL stall_hold_valid got %0b want 0", rec_valid); end
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    vectors++; if (got.size() != 2) begin miscompares++; $display("FAIL stall_count got %0d want 2", got.size()); end
    for (int i = 0; i < 2; i++) begin
      if (i < got.size()) begin
        vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL stall_rec%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_overflow;
    logic [REC_W-1:0] exp;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      idle(k - 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
    end
    idle(1);
    vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got %0b want 1", rec_valid); end
    vectors++; if (txn_count !== CNT_W'(10)) begin miscompares++; $display("FAIL ovf_txn got %0d want 10", txn_count); end
    vectors++; if (drop_count !== CNT_W'(2)) begin miscompares++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = mk(1'b0, 0, (i == 0) ? 0 : i + 1, i + 1);
      vectors++; if (rec_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_valid%0d got %0b want 1", i, rec_valid); end
      vectors++; if (rec_data !== exp) begin miscompares++; $display("FAIL ovf_drain_rec%0d got %h want %h", i, rec_data, exp); end
      @(posedge ap_clk); #1;
    end
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %0b want 0", rec_valid); end
  endtask

  task automatic test_reset_mid_busy;
    logic [REC_W-1:0] exp;
    do_reset();
    exp = mk(1'b0, 0, 0, 2);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    ap_rst = 1'b1;
    #2;
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %0b want 0", rec_valid); end
    vectors++; if (rec_data !== '0) begin miscompares++; $display("FAIL rst_mid_data got %h want 0", rec_data); end
    vectors++; if (txn_count !== '0) begin miscompares++; $display("FAIL rst_mid_txn got %0d want 0", txn_count); end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    vectors++; if (rec_valid !== 1'b0) begin miscompares++; $display("FAIL rst_lost_valid got %0b want 0", rec_valid); end
    vectors++; if (txn_count !== '0) begin miscompares++; $display("FAIL rst_lost_txn got %0d want 0", txn_count); end
    rec_ready = 1'b1;
    got.delete();
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3);
    vectors++; if (got.size() != 1) begin miscompares++; $display("FAIL rst_after_count got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      vectors++; if (got[0] !== exp) begin miscompares++; $display("FAIL rst_after_rec got %h want %h", got[0], exp); end
    end
    vectors++; if (txn_count !== CNT_W'(1)) begin miscompares++; $display("FAIL rst_after_txn got %0d want 1", txn_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_latency();
    test_stall();
    test_overflow();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
